// File: rtl/monitor_ctrl_pkg.sv
// Shared constants for the monitor read controller.
// Contents: FSM state encoding, bank indices, default watchdog limit.
// No logic; imported by monitor_read_ctrl.
package monitor_ctrl_pkg;

    // FSM state encoding (2 bits)
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARM       = 2'd1;
    localparam logic [1:0] ST_ISSUE     = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // Bank indices within the DDR stats region
    localparam logic BANK_EVEN = 1'b0;
    localparam logic BANK_ODD  = 1'b1;

    // Default number of WAIT_DONE cycles before err_timeout is raised
    localparam int TIMEOUT_CYC_DEF = 1000000;

endpackage

// File: rtl/monitor_read_ctrl.sv
// Purpose: sequences double-buffered stats drains; one DDR read per full bank, odd/even alternating.
// Latency: fill pulse at N -> bank_pending at N+1 -> start_valid at N+2 (when armed and idle).
// Backpressure: start held until ddr_read_start_ready; waits indefinitely for finish, watchdog only flags.
// Ports: clk/aresetn (sync, active-low); cfg_en/cfg_clr control; wr_full_valid/wr_full_bank from writer;
//        bank_pending to writer; ddr_read_start* / ddr_read_finish* handshakes with monitor_adaptor;
//        busy, round_cnt, overrun_cnt, err_timeout, err_fail status for the host register file.
module monitor_read_ctrl
    import monitor_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             cfg_en,
    input  logic             cfg_clr,
    input  logic             wr_full_valid,
    input  logic             wr_full_bank,
    output logic [1:0]       bank_pending,
    output logic             ddr_read_start,
    output logic             ddr_read_start_valid,
    input  logic             ddr_read_start_ready,
    output logic             odd_even_flag,
    input  logic             ddr_read_finish,
    input  logic             ddr_read_finish_valid,
    output logic             ddr_read_finish_ready,
    output logic             busy,
    output logic [CNT_W-1:0] round_cnt,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic             err_timeout,
    output logic             err_fail
);

    localparam int               TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]  TO_ONE = TO_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]      state;
    logic            last_bank;
    logic [TO_W-1:0] to_cnt;

    logic            fill;
    logic            start_hs;
    logic            fin_hs;
    logic            fin_ok;
    logic [1:0]      done_clr;
    logic [1:0]      set_mask;
    logic [1:0]      pend_nxt;
    logic            overrun_hit;
    logic            chosen_bank;

    always_comb begin
        fill     = wr_full_valid && cfg_en;
        start_hs = (state == ST_ISSUE) && ddr_read_start_ready;
        fin_hs   = (state == ST_WAIT_DONE) && ddr_read_finish_valid;
        fin_ok   = fin_hs && ddr_read_finish;

        done_clr = fin_ok ? (2'b01 << odd_even_flag) : 2'b00;
        set_mask = fill ? (2'b01 << wr_full_bank) : 2'b00;

        // Clears (host or completed drain) apply first, so a same-cycle fill always wins.
        pend_nxt = (cfg_clr ? 2'b00 : (bank_pending & ~done_clr)) | set_mask;

        // Refilling a bank that is still pending is an overrun, unless that bank is
        // being cleared this very cycle (the fill then simply re-arms it).
        overrun_hit = fill && bank_pending[wr_full_bank]
                      && !cfg_clr && !done_clr[wr_full_bank];

        // With both banks pending, serve the one not served last so neither starves.
        chosen_bank = (bank_pending == 2'b11) ? ~last_bank : bank_pending[1];
    end

    assign ddr_read_start        = (state == ST_ISSUE);
    assign ddr_read_start_valid  = (state == ST_ISSUE);
    assign ddr_read_finish_ready = (state == ST_WAIT_DONE);
    assign busy                  = (state == ST_ISSUE) || (state == ST_WAIT_DONE);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            last_bank     <= BANK_ODD;
            odd_even_flag <= BANK_EVEN;
            bank_pending  <= 2'b00;
            round_cnt     <= '0;
            overrun_cnt   <= '0;
            err_timeout   <= 1'b0;
            err_fail      <= 1'b0;
            to_cnt        <= '0;
        end else begin
            bank_pending <= pend_nxt;

            if (cfg_clr) begin
                overrun_cnt <= '0;
            end else if (overrun_hit && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + CNT_ONE;
            end

            if (cfg_clr) begin
                round_cnt <= '0;
            end else if (fin_ok && (round_cnt != '1)) begin
                round_cnt <= round_cnt + CNT_ONE;
            end

            if (cfg_clr) begin
                err_fail <= 1'b0;
            end else if (fin_hs && !ddr_read_finish) begin
                err_fail <= 1'b1;
            end

            // Watchdog: restarts on WAIT_DONE entry, saturates at the limit and only flags;
            // the outstanding read is never abandoned.
            if (start_hs) begin
                to_cnt <= '0;
            end else if ((state == ST_WAIT_DONE) && (to_cnt != TO_MAX)) begin
                to_cnt <= to_cnt + TO_ONE;
            end

            if (cfg_clr) begin
                err_timeout <= 1'b0;
            end else if ((state == ST_WAIT_DONE) && (to_cnt == TO_MAX - TO_ONE)) begin
                err_timeout <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_en) begin
                        state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (!cfg_en) begin
                        state <= ST_IDLE;
                    end else if (bank_pending != 2'b00) begin
                        odd_even_flag <= chosen_bank;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ddr_read_start_ready) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (ddr_read_finish_valid) begin
                        last_bank <= odd_even_flag;
                        state     <= cfg_en ? ST_ARM : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_monitor_read_ctrl.sv
// Bench for monitor_read_ctrl: directed scenarios, expected start banks queued by the
// stimulus and popped by a separate handshake monitor; status checked against constants.
module tb_monitor_read_ctrl;

    localparam int CNT_W = 16;
    localparam int TO_C  = 20;

    logic             clk = 1'b0;
    logic             aresetn;
    logic             cfg_en;
    logic             cfg_clr;
    logic             wr_full_valid;
    logic             wr_full_bank;
    logic [1:0]       bank_pending;
    logic             ddr_read_start;
    logic             ddr_read_start_valid;
    logic             ddr_read_start_ready;
    logic             odd_even_flag;
    logic             ddr_read_finish;
    logic             ddr_read_finish_valid;
    logic             ddr_read_finish_ready;
    logic             busy;
    logic [CNT_W-1:0] round_cnt;
    logic [CNT_W-1:0] overrun_cnt;
    logic             err_timeout;
    logic             err_fail;

    int vectors     = 0;
    int miscompares = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    monitor_read_ctrl #(.TIMEOUT_CYC(TO_C), .CNT_W(CNT_W)) dut (
        .clk                   (clk),
        .aresetn               (aresetn),
        .cfg_en                (cfg_en),
        .cfg_clr               (cfg_clr),
        .wr_full_valid         (wr_full_valid),
        .wr_full_bank          (wr_full_bank),
        .bank_pending          (bank_pending),
        .ddr_read_start        (ddr_read_start),
        .ddr_read_start_valid  (ddr_read_start_valid),
        .ddr_read_start_ready  (ddr_read_start_ready),
        .odd_even_flag         (odd_even_flag),
        .ddr_read_finish       (ddr_read_finish),
        .ddr_read_finish_valid (ddr_read_finish_valid),
        .ddr_read_finish_ready (ddr_read_finish_ready),
        .busy                  (busy),
        .round_cnt             (round_cnt),
        .overrun_cnt           (overrun_cnt),
        .err_timeout           (err_timeout),
        .err_fail              (err_fail)
    );

    // Start-handshake monitor: inputs change just after posedge, so the values seen at
    // negedge are the ones the next posedge will sample.
    always @(negedge clk) begin
        if (aresetn && ddr_read_start_valid && ddr_read_start_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL start_unexpected: issued bank %0d, no start expected", odd_even_flag);
            end else begin
                logic eb;
                eb = exp_q.pop_front();
                if (odd_even_flag !== eb || ddr_read_start !== 1'b1) begin
                    miscompares++;
                    $display("FAIL start_bank: got bank %0d payload %0d, want bank %0d payload 1",
                             odd_even_flag, ddr_read_start, eb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic fill(input logic bank);
        wr_full_valid = 1'b1;
        wr_full_bank  = bank;
        tick();
        wr_full_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!ddr_read_start_valid && n < 50) begin
            tick();
            n++;
        end
        if (!ddr_read_start_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_start: start_valid %0d after 50 cycles, want 1", ddr_read_start_valid);
        end
    endtask

    task automatic accept();
        wait_start();
        ddr_read_start_ready = 1'b1;
        tick();
        ddr_read_start_ready = 1'b0;
    endtask

    task automatic finish(input logic ok);
        int n = 0;
        while (!ddr_read_finish_ready && n < 50) begin
            tick();
            n++;
        end
        if (!ddr_read_finish_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_finish_rdy: finish_ready %0d after 50 cycles, want 1", ddr_read_finish_ready);
        end
        ddr_read_finish_valid = 1'b1;
        ddr_read_finish       = ok;
        tick();
        ddr_read_finish_valid = 1'b0;
        ddr_read_finish       = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pending"}, 32'(bank_pending), 0);
        chk({tag, "_flag"},    32'(odd_even_flag), 0);
        chk({tag, "_busy"},    32'(busy), 0);
        chk({tag, "_svld"},    32'(ddr_read_start_valid), 0);
        chk({tag, "_frdy"},    32'(ddr_read_finish_ready), 0);
        chk({tag, "_round"},   32'(round_cnt), 0);
        chk({tag, "_ovr"},     32'(overrun_cnt), 0);
        chk({tag, "_etmo"},    32'(err_timeout), 0);
        chk({tag, "_efail"},   32'(err_fail), 0);
    endtask

    initial begin
        aresetn = 1'b0; cfg_en = 1'b0; cfg_clr = 1'b0;
        wr_full_valid = 1'b0; wr_full_bank = 1'b0;
        ddr_read_start_ready = 1'b0; ddr_read_finish = 1'b0; ddr_read_finish_valid = 1'b0;
        tick(); tick();
        check_all_zero("rst");

        // Single fill of bank 1, start held under backpressure
        aresetn = 1'b1; cfg_en = 1'b1;
        tick(); tick();
        exp_q.push_back(1'b1);
        fill(1'b1);
        chk("t1_pend_n1", 32'(bank_pending), 2);
        chk("t1_svld_n1", 32'(ddr_read_start_valid), 0);
        tick();
        chk("t1_svld_n2", 32'(ddr_read_start_valid), 1);
        chk("t1_flag",    32'(odd_even_flag), 1);
        chk("t1_busy",    32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_svld_hold", 32'(ddr_read_start_valid), 1);
        end
        accept();
        chk("t1_svld_drop", 32'(ddr_read_start_valid), 0);
        chk("t1_frdy",      32'(ddr_read_finish_ready), 1);
        finish(1'b1);
        chk("t1_pend_done", 32'(bank_pending), 0);
        chk("t1_round",     32'(round_cnt), 1);
        chk("t1_busy_done", 32'(busy), 0);

        // Both banks pending after reset: bank 0 first, then bank 1
        aresetn = 1'b0; cfg_en = 1'b0;
        tick();
        aresetn = 1'b1; cfg_en = 1'b1;
        fill(1'b1);
        cfg_en = 1'b0;
        tick();
        cfg_en = 1'b1;
        fill(1'b0);
        chk("t2_pend_both", 32'(bank_pending), 3);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        accept();
        finish(1'b1);
        chk("t2_pend_mid", 32'(bank_pending), 2);
        accept();
        finish(1'b1);
        tick();
        chk("t2_round", 32'(round_cnt), 2);
        chk("t2_pend",  32'(bank_pending), 0);
        chk("t2_busy",  32'(busy), 0);

        // Overrun: bank 0 refilled before it is drained
        cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
        chk("clr_round", 32'(round_cnt), 0);
        exp_q.push_back(1'b0);
        fill(1'b0);
        fill(1'b0);
        chk("t3_ovr", 32'(overrun_cnt), 1);
        accept();
        finish(1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("t3_round", 32'(round_cnt), 1);
        chk("t3_pend",  32'(bank_pending), 0);
        chk("t3_busy",  32'(busy), 0);

        // Failure then retry with timeout
        cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        fill(1'b1);
        accept();
        finish(1'b0);
        chk("t4_efail", 32'(err_fail), 1);
        chk("t4_pend",  32'(bank_pending), 2);
        chk("t4_round", 32'(round_cnt), 0);
        accept();
        for (int i = 0; i < 10; i++) tick();
        chk("t4_etmo_early", 32'(err_timeout), 0);
        for (int i = 0; i < 12; i++) tick();
        chk("t4_etmo",      32'(err_timeout), 1);
        chk("t4_busy_wait", 32'(busy), 1);
        finish(1'b1);
        chk("t4_pend_done", 32'(bank_pending), 0);
        chk("t4_round_done", 32'(round_cnt), 1);

        // cfg_en dropped during WAIT_DONE
        exp_q.push_back(1'b0);
        fill(1'b0);
        accept();
        cfg_en = 1'b0;
        finish(1'b1);
        chk("t5_round", 32'(round_cnt), 2);
        chk("t5_pend",  32'(bank_pending), 0);
        cfg_en = 1'b1;
        fill(1'b1);
        cfg_en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_pend_held", 32'(bank_pending), 2);
        chk("t5_idle",      32'(busy), 0);
        chk("t5_q_before",  32'(exp_q.size()), 0);
        exp_q.push_back(1'b1);
        cfg_en = 1'b1;
        accept();
        finish(1'b1);
        chk("t5_round_end", 32'(round_cnt), 3);

        // cfg_clr clears counters and sticky errors
        chk("t6_efail_pre", 32'(err_fail), 1);
        cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
        chk("t6_round", 32'(round_cnt), 0);
        chk("t6_ovr",   32'(overrun_cnt), 0);
        chk("t6_efail", 32'(err_fail), 0);
        chk("t6_etmo",  32'(err_timeout), 0);

        // Reset pulse during WAIT_DONE
        exp_q.push_back(1'b0);
        fill(1'b0);
        accept();
        chk("t7_frdy_pre", 32'(ddr_read_finish_ready), 1);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        check_all_zero("t7");
        tick(); tick();
        chk("t7_q_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/monitor_read_ctrl.md
Name: monitor_read_ctrl

Overview:
- Sequencer for monitor_adaptor; tracks which half (bank) of the DDR stats region is full and when it is safe to drain it.
- Issues one ddr_read_start transaction per full bank, with odd_even_flag set to that bank.
- Waits for the ddr_read_finish handshake, then releases the bank to the writer.
- Sits between the stats writer (bank-full pulses) and monitor_adaptor's control handshakes; adds sticky error/overrun status for the host register file.

Parameters:
- TIMEOUT_CYC, 1000000, cycles in WAIT_DONE before err_timeout is set.
- CNT_W, 16, width of the overrun and round counters (saturating).

Ports:
- clk  in  1  system clock
- aresetn  in  1  reset; synchronous, active-low
- cfg_en  in  1  enable sequencing; level
- cfg_clr  in  1  one-cycle pulse; clears pending bits, counters and sticky errors
- wr_full_valid  in  1  pulse; writer finished filling bank wr_full_bank
- wr_full_bank  in  1  bank index qualified by wr_full_valid (0 = even, 1 = odd)
- bank_pending  out  2  bank i full and not yet drained; writer must not reuse a set bank
- ddr_read_start  out  1  start command payload, driven 1 with valid
- ddr_read_start_valid  out  1  start command valid
- ddr_read_start_ready  in  1  monitor_adaptor accepts start
- odd_even_flag  out  1  bank being drained; stable from ISSUE entry until WAIT_DONE exit
- ddr_read_finish  in  1  completion status (1 = ok, 0 = fail)
- ddr_read_finish_valid  in  1  completion valid
- ddr_read_finish_ready  out  1  controller accepts completion
- busy  out  1  state is ISSUE or WAIT_DONE
- round_cnt  out  CNT_W  successful drains, saturating
- overrun_cnt  out  CNT_W  fill pulses for an already pending bank, saturating
- err_timeout  out  1  sticky, set when TIMEOUT_CYC is reached
- err_fail  out  1  sticky, set on a finish with ddr_read_finish = 0

Behaviour:
- Reset (aresetn = 0 at a clk edge):
  - state = IDLE.
  - All outputs 0: bank_pending = 2'b00, odd_even_flag = 0, counters = 0, sticky errors = 0.
  - last_bank = 1, so the first served bank is 0 when both are pending.
- Pending capture:
  - When wr_full_valid && cfg_en: set bank_pending[wr_full_bank].
  - If that bit is already set and is not being cleared in the same cycle, increment overrun_cnt (saturating).
  - Same-cycle clear and set of the same bank: set wins, no overrun.
  - Fill pulses while cfg_en = 0 are ignored.
- States:
  - IDLE: if cfg_en, go to ARM.
  - ARM:
    - If cfg_en = 0, go to IDLE.
    - Else if any bit of bank_pending is set, choose the bank: if only one is set, take it; if both are set, take ~last_bank.
    - Register odd_even_flag = chosen bank and go to ISSUE.
  - ISSUE:
    - ddr_read_start = 1 and ddr_read_start_valid = 1, held until sampled with ddr_read_start_ready = 1.
    - Then go to WAIT_DONE; start/valid deassert on the following cycle.
  - WAIT_DONE:
    - ddr_read_finish_ready = 1 and the timeout counter runs.
    - On ddr_read_finish_valid:
      - If ddr_read_finish = 1: clear bank_pending[odd_even_flag] and increment round_cnt.
      - Else: set err_fail; the bank stays pending and will be retried.
      - In both cases, last_bank = odd_even_flag, and go to ARM if cfg_en else IDLE.
- Latency: a wr_full_valid pulse at cycle N gives bank_pending at N+1, ISSUE with start_valid high at N+2 (when idle in ARM).
- Timeout:
  - The counter resets on entry to WAIT_DONE.
  - On reaching TIMEOUT_CYC, set err_timeout and freeze the counter.
  - The FSM keeps waiting; it never abandons an outstanding read.
- cfg_en falling mid-operation: the current ISSUE/WAIT_DONE completes normally, then the FSM goes to IDLE; pending bits are retained.
- cfg_clr:
  - Clears bank_pending, both counters and both sticky errors; does not change state.
  - In ISSUE/WAIT_DONE, the in-flight bank's completion still finishes normally (its clear is a no-op).
  - Same-cycle cfg_clr and fill pulse: the fill wins, the bit is set and there is no overrun.
- Odd/even alternation guarantees neither bank starves under continuous fills.

Decomposition:
- Package monitor_ctrl_pkg:
  - state encoding IDLE/ARM/ISSUE/WAIT_DONE (2 bits);
  - BANK_EVEN = 0, BANK_ODD = 1;
  - default TIMEOUT_CYC.
- No sub-module; the watchdog counter stays inline.

Test Plan:
- Single fill: cfg_en = 1, wr_full_valid with bank 1 at cycle 10.
  - Expect start_valid high at cycle 12 with odd_even_flag = 1.
  - Hold start_ready low for 3 cycles; start_valid must hold.
  - finish_valid with finish = 1 gives bank_pending = 00 and round_cnt = 1.
- Both banks pending after reset: serve order is bank 0 then bank 1, round_cnt = 2, busy low afterwards.
- Overrun: two fills of bank 0 before drain gives overrun_cnt = 1, with only one drain issued.
- Failure and timeout, with TIMEOUT_CYC = 20:
  - finish = 0 gives err_fail = 1, bank still pending, and a second ISSUE on the same bank.
  - Withholding finish_valid for 20 cycles sets err_timeout; a late finish = 1 then completes normally.
- cfg_en dropped during WAIT_DONE: the read completes, the FSM goes to IDLE, and a later fill sets pending with no ISSUE until cfg_en returns.
- Reset: aresetn low for 1 cycle during WAIT_DONE returns all outputs to 0 on the next cycle; cfg_clr pulse zeroes the counters and errors.
